// File: rtl/alu_pkg.sv
// Shared ALU front-end definitions: operand widths, opcode values and
// operand-entry sequencer states (the state encoding is shown on the LEDs).
package alu_pkg;

   localparam int DATA_W = 7;
   localparam int OP_W   = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_CMP = 2'b10,
      OP_MUL = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      RUN     = 2'b11
   } seq_state_e;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, counter debouncer and a
// single-cycle press pulse on each debounced rising edge.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse
);

   localparam int CNT_W = 24;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             prev_q;
   logic [1:0]       fill_q;
   logic             armed_q, armed_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // A button held through reset must be seen released before a rise
      // counts as a press; fill_q marks when the synchronizer holds real data.
      armed_d = armed_q | (fill_q[1] & ~sync_q[1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         fill_q   <= '0;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_raw};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         fill_q   <= {fill_q[0], 1'b1};
         armed_q  <= armed_d;
      end
   end

   assign btn_level   = stable_q;
   assign press_pulse = stable_q & ~prev_q & armed_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand entry controller: ENTER steps through A, B, opcode, RUN; CLEAR
// zeroes everything. Drives registered a/b/opcode to the ALU.
module alu_operand_sequencer #(
   parameter int          DATA_W          = alu_pkg::DATA_W,
   parameter int          OP_W            = alu_pkg::OP_W,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sw,
   input  logic              btn_enter,
   input  logic              btn_clear,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [OP_W-1:0]   opcode,
   output logic              operands_valid,
   output logic [1:0]        phase
);

   import alu_pkg::*;

   logic enter_level, enter_pulse;
   logic clear_level, clear_pulse;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_enter),
      .btn_level  (enter_level),
      .press_pulse(enter_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_clear),
      .btn_level  (clear_level),
      .press_pulse(clear_pulse)
   );

   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      // Clear has priority; a coincident enter is dropped.
      if (clear_pulse) begin
         state_d = LOAD_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         valid_d = 1'b0;
      end else if (enter_pulse) begin
         case (state_q)
            LOAD_A: begin
               a_d     = sw;
               state_d = LOAD_B;
            end
            LOAD_B: begin
               b_d     = sw;
               state_d = LOAD_OP;
            end
            LOAD_OP: begin
               op_d    = sw[OP_W-1:0];
               valid_d = 1'b1;
               state_d = RUN;
            end
            default: begin
               valid_d = 1'b0;
               state_d = LOAD_A;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   assign a              = a_q;
   assign b              = b_q;
   assign opcode         = op_q;
   assign operands_valid = valid_q;
   assign phase          = state_q;

endmodule
